// File: rtl/pio_out_pulse_if.sv
// Avalon-MM s1 slave bus bundle for the pio_out_pulse register block.
interface pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_out_pulse.sv
// Parametrised output PIO with set/clear registers and a timed-pulse engine.
// Optional macro PIO_OUT_PULSE_IRQ_EN adds a level irq output mirroring the done flag.
module pio_out_pulse #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_out_pulse_if.slave   bus,
  output logic [WIDTH-1:0] out_port
`ifdef PIO_OUT_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_LEN    = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]       state, state_d;
  logic [WIDTH-1:0] out_q, out_d, out_wr;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;
  logic             busy;
  logic             wr;
  logic [WIDTH-1:0] wd_bits;
  logic [CNT_W-1:0] wd_len;
  logic [31:0]      rd;
  logic             unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd_bits   = bus.writedata[WIDTH-1:0];
  assign wd_len    = bus.writedata[CNT_W-1:0];
  assign busy      = (state == ACTIVE);
  assign unused_wd = ^bus.writedata;

  // CPU-side write result on out_port, before any pulse toggle is folded in
  always_comb begin
    out_wr = out_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:  out_wr = wd_bits;
        ADDR_SET:   out_wr = out_q | wd_bits;
        ADDR_CLEAR: out_wr = out_q & ~wd_bits;
        default:    out_wr = out_q;
      endcase
    end
  end

  // Next-state and pulse engine; set events are applied after write-1-to-clear
  always_comb begin
    state_d   = state;
    out_d     = out_wr;
    len_d     = len_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    done_d    = done_q;

    if (wr && bus.address == ADDR_LEN)
      len_d = (wd_len == '0) ? CNT_W'(1) : wd_len;

    if (wr && bus.address == ADDR_STATUS) begin
      if (bus.writedata[1]) overrun_d = 1'b0;
      if (bus.writedata[2]) done_d    = 1'b0;
    end

    case (state)
      IDLE: begin
        if (wr && bus.address == ADDR_PULSE && wd_bits != '0) begin
          out_d   = out_wr ^ wd_bits;
          mask_d  = wd_bits;
          cnt_d   = len_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (wr && bus.address == ADDR_PULSE)
          overrun_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          out_d   = out_wr ^ mask_q;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_q     <= RESET_VALUE;
      len_q     <= CNT_W'(1);
      cnt_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      out_q     <= out_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  // Read mux; write-only and unmapped addresses return zero
  always_comb begin
    case (bus.address)
      ADDR_DATA:   rd = 32'(out_q);
      ADDR_LEN:    rd = 32'(len_q);
      ADDR_STATUS: rd = {29'd0, done_q, overrun_q, busy};
      default:     rd = 32'd0;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = out_q;

`ifdef PIO_OUT_PULSE_IRQ_EN
  assign irq = done_q;
`endif

endmodule
